// File: rtl/sram_if_pkg.sv
// Shared definitions for the SRAM request adapter slice.
// Holds the default SRAM geometry and the response record carried through
// the response FIFO ({rdata, tag, err}).
package sram_if_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned TAG_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous show-ahead FIFO for read responses.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push         write push_data at the next edge
//   push_data    entry to store
//   pop          drop the head entry at the next edge
//   pop_data     current head entry (valid while count != 0)
//   count        number of stored entries, 0..DEPTH
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sram_rsp_fifo
    import sram_if_pkg::*;
#(
    parameter type         T     = sram_rsp_t,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 pop_data,
    output logic [CNT_W-1:0] count
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a single-port synchronous SRAM wrapper.
// Accepted requests drive the SRAM strobes combinationally; reads come back
// two cycles after accept through a response FIFO so a stalled consumer
// never loses data.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_we/addr/wdata/tag       request payload (we=1 write, 0 read)
//   rsp_valid/rsp_ready         read response handshake
//   rsp_rdata/rsp_tag/rsp_err   read response payload
//   sram_cen_n/wen/addr/wdata   SRAM strobes (cen_n active low)
//   sram_rdata                  SRAM registered read data
// Optional feature: define SRAM_ADDR_CHECK_EN to reject addresses >= DEPTH
// (no SRAM access; reads answer rdata=0, err=1). Undefined: every address
// goes to the SRAM and rsp_err is constant 0.
module sram_req_adapter #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DEPTH     = 400,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              sram_cen_n,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    import sram_if_pkg::*;

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } rsp_t;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             rd_pend;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic             pop;
    logic             accept;
    logic             addr_ok;
    rsp_t             push_data;
    rsp_t             head;

`ifdef SRAM_ADDR_CHECK_EN
    assign addr_ok = (32'(req_addr) < DEPTH);
    assign rsp_err = rsp_valid && head.err;
`else
    logic unused_depth;
    assign unused_depth = ^DEPTH;
    assign addr_ok      = 1'b1;
    assign rsp_err      = 1'b0;
`endif

    assign pop       = rsp_valid && rsp_ready;
    // Slots already committed: buffered entries plus the read in flight,
    // minus the one leaving this cycle (combinational path from rsp_ready).
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(rd_pend) - (CNT_W+1)'(pop);
    assign req_ready = rst_n && (occupancy < (CNT_W+1)'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    assign sram_cen_n = !(accept && addr_ok);
    assign sram_wen   = rst_n && req_we;
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            rd_pend <= accept && !req_we;
            if (accept && !req_we) begin
                tag_q <= req_tag;
                err_q <= !addr_ok;
            end
        end
    end

    // sram_rdata is sampled one cycle after the read accept, before any
    // write accepted in that cycle can change it.
    always_comb begin
        push_data       = '0;
        push_data.rdata = err_q ? '0 : sram_rdata;
        push_data.tag   = tag_q;
        push_data.err   = err_q;
    end

    sram_rsp_fifo #(
        .T     (rsp_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign rsp_valid = (fifo_count != '0);
    assign rsp_rdata = head.rdata;
    assign rsp_tag   = head.tag;

endmodule
